uio_burst_arbiter: RTL and testbench
====================================

UIO_BURST_ARBITER -- requirements
Module: uio_burst_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, fixed at 4 in this revision.
REQ-002 Parameter MAX_BURST, default 8: maximum bytes per grant before forced release, legal range 1..15.
REQ-003 Ports, in this order:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design enable; low freezes all state.
- req  in  4  per-requester request, level.
- last  in  4  per-requester end-of-burst flag, qualified by that requester's current byte.
- data  in  32  byte i on data[8i+7:8i].
- bus_ready  in  1  sink accepts the byte on uio_out this cycle.
- gnt  out  4  one-hot grant, registered; all zero when no grant.
- ack  out  4  byte-accepted strobe, one-hot, combinational.
- uio_out  out  8  bus data.
- uio_oe  out  8  bus drive enable, all-ones or all-zeros.
- busy  out  1  high in XFER and GAP.
- cur_id  out  2  index of the granted requester; 0 when none.

Function
REQ-004 FSM states: IDLE, XFER, GAP; state register, gnt, cur_id, byte counter and round-robin pointer all registered.
REQ-005 IDLE: if ena=1 and req!=0, select the winner and enter XFER next cycle with gnt set; otherwise stay in IDLE.
REQ-006 Request-to-grant latency: exactly 1 cycle.
REQ-007 Winner: first set req bit scanning upward from (last_winner+1) mod 4 with wrap-around.
REQ-008 After reset, last_winner=3, so requester 0 has top priority.
REQ-009 last_winner updates only on entry to XFER.
REQ-010 XFER outputs: uio_oe=8'hFF; uio_out=data byte of cur_id.
REQ-011 IDLE and GAP outputs: uio_oe=8'h00; uio_out=8'h00.
REQ-012 Transfer condition: ena=1, state XFER, req[cur_id]=1 and bus_ready=1; ack[cur_id]=1 in that cycle; byte counter increments by 1.
REQ-013 ack is zero in every other case.
REQ-014 Burst end: when a transfer occurs with last[cur_id]=1, or the transfer is byte number MAX_BURST, go to GAP next cycle and clear gnt.
REQ-015 Abort: req[cur_id]=0 in XFER means no ack; go to GAP next cycle and clear gnt.
REQ-016 Only completed transfers are counted.
REQ-017 GAP lasts exactly 1 cycle for bus turnaround, then IDLE; arbitration resumes from IDLE, so the minimum back-to-back grant spacing is 2 idle-bus cycles.
REQ-018 bus_ready=0 in XFER stalls indefinitely with no timeout; uio_out stays stable.
REQ-019 Byte counter is 4 bits, cleared on entry to XFER, and never wraps because MAX_BURST<=15.
REQ-020 ena=0 freezes all registers and forces ack=0; outputs continue to reflect the frozen state.
REQ-021 Simultaneous last and MAX_BURST on the same transfer: treated as a single burst end.

Reset
REQ-022 rst=1 at a clock edge forces, at that edge, state=IDLE, gnt=0, cur_id=0, counter=0, last_winner=3, regardless of ena.
REQ-023 Outputs after reset: uio_oe=0, uio_out=0, busy=0, ack=0.
REQ-024 Reset asserted mid-XFER abandons the burst; the next cycle is IDLE with the bus released.

Verification
REQ-025 Reset, then req=4'b0001, data byte0 = 8'hA5 constant, bus_ready=1, last[0] high on the 3rd byte -> gnt=0001 one cycle after req; three ack[0] pulses; uio_oe=FF for 3 cycles; GAP; IDLE.
REQ-026 req=4'b1111 held, last=4'b1111, bus_ready=1 -> grants in order 0,1,2,3,0, each 1 byte, separated by GAP+IDLE cycles.
REQ-027 req=4'b0100, last=0, bus_ready=1 -> exactly 8 acks, forced release, then re-grant to requester 2 after GAP and IDLE.
REQ-028 In XFER with bus_ready=0 for 5 cycles, then 1 -> no ack during the stall; uio_out stable; one ack afterwards.
REQ-029 Mid-burst, requester drops req -> no ack that cycle; GAP next; counter does not include the aborted byte.
REQ-030 rst=1 asserted during XFER, and ena=0 held for 3 cycles in XFER -> after reset all outputs are zero; while ena=0, state and gnt are unchanged and ack=0.

Source files
------------

// File: rtl/uio_burst_arbiter.sv
// Round-robin burst arbiter: grants one of four byte sources the shared uio bus,
// moves bytes while the sink is ready, and releases on last, burst limit or abort.
module uio_burst_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     last,
    input  logic [8*NREQ-1:0]   data,
    input  logic                bus_ready,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [7:0]          uio_out,
    output logic [7:0]          uio_oe,
    output logic                busy,
    output logic [1:0]          cur_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      cur_id_q, cur_id_d;
    logic [1:0]      last_win_q, last_win_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [1:0]      cand;
    logic [1:0]      winner;
    logic            win_found;
    logic            xfer_ok;
    logic [3:0]      cnt_inc;
    logic            burst_end;
    logic [7:0]      byte_sel;

    // Scan upward from the requester after the previous winner, wrapping at 4.
    always_comb begin
        cand      = 2'd0;
        winner    = 2'd0;
        win_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = last_win_q + 2'(i + 1);
            if (!win_found && req[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        byte_sel = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (cur_id_q == 2'(i)) begin
                byte_sel = data[8*i +: 8];
            end
        end
    end

    assign xfer_ok   = ena && (state_q == XFER) && req[cur_id_q] && bus_ready;
    assign cnt_inc   = cnt_q + 4'd1;
    assign burst_end = last[cur_id_q] || (cnt_inc == MAX_BURST_C);

    always_comb begin
        ack = '0;
        if (xfer_ok) begin
            ack[cur_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cur_id_d   = cur_id_q;
        last_win_d = last_win_q;
        cnt_d      = cnt_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_d         = XFER;
                        gnt_d           = '0;
                        gnt_d[winner]   = 1'b1;
                        cur_id_d        = winner;
                        last_win_d      = winner;
                        cnt_d           = 4'd0;
                    end
                end
                XFER: begin
                    // A dropped request abandons the burst without moving a byte.
                    if (!req[cur_id_q]) begin
                        state_d  = GAP;
                        gnt_d    = '0;
                        cur_id_d = 2'd0;
                    end else if (bus_ready) begin
                        cnt_d = cnt_inc;
                        if (burst_end) begin
                            state_d  = GAP;
                            gnt_d    = '0;
                            cur_id_d = 2'd0;
                        end
                    end
                end
                GAP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            cur_id_q   <= 2'd0;
            last_win_q <= 2'd3;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cur_id_q   <= cur_id_d;
            last_win_q <= last_win_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign cur_id  = cur_id_q;
    assign busy    = (state_q != IDLE);
    assign uio_oe  = (state_q == XFER) ? 8'hFF : 8'h00;
    assign uio_out = (state_q == XFER) ? byte_sel : 8'h00;

endmodule

// File: tb/tb_uio_burst_arbiter.sv
// Bench for uio_burst_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of owner, byte count and turnaround.
module tb_uio_burst_arbiter;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic        bus_ready;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        busy;
    logic [1:0]  cur_id;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the bus (-1 none), whether a turnaround cycle is pending,
    // bytes moved in the current burst, and the most recent winner.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_bytes = 0;
    int m_prev  = 3;

    int         ack_cnt;
    int         oe_cnt;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic [3:0] prev_gnt;
    logic [7:0] held_byte;

    always #5 clk = ~clk;

    uio_burst_arbiter #(.NREQ(4), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .last(last), .data(data),
        .bus_ready(bus_ready), .gnt(gnt), .ack(ack), .uio_out(uio_out),
        .uio_oe(uio_oe), .busy(busy), .cur_id(cur_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        logic [7:0] e_out;
        logic [7:0] e_oe;
        logic [1:0] e_id;
        logic       e_busy;
        logic [1:0] idx;
        e_gnt  = 4'd0;
        e_ack  = 4'd0;
        e_out  = 8'h00;
        e_oe   = 8'h00;
        e_id   = 2'd0;
        e_busy = m_gap;
        if (m_owner >= 0) begin
            e_gnt  = 4'(1 << m_owner);
            e_id   = 2'(m_owner);
            e_oe   = 8'hFF;
            e_out  = data[8*m_owner +: 8];
            e_busy = 1'b1;
            if (ena && req[m_owner] && bus_ready) e_ack = 4'(1 << m_owner);
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("uio_out", 32'(uio_out), 32'(e_out));
        chk("uio_oe", 32'(uio_oe), 32'(e_oe));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cur_id", 32'(cur_id), 32'(e_id));
        if (ack != 4'd0) ack_cnt++;
        if (uio_oe == 8'hFF) oe_cnt++;
        if (gnt != 4'd0 && prev_gnt == 4'd0) begin
            idx = 2'd0;
            for (int i = 0; i < 4; i++) if (gnt[i]) idx = 2'(i);
            got_q.push_back(idx);
        end
        prev_gnt = gnt;
    endtask

    task automatic model_update();
        if (rst) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_bytes = 0;
            m_prev  = 3;
        end else if (!ena) begin
            // everything holds
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (bus_ready) begin
                m_bytes++;
                if (last[m_owner] || m_bytes == MAXB) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                end
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && req[(m_prev + k) % 4]) begin
                    m_owner = (m_prev + k) % 4;
                    m_bytes = 0;
                end
            end
            if (m_owner >= 0) m_prev = m_owner;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clr_tally();
        ack_cnt = 0;
        oe_cnt  = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_grants(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_order"}, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; req = 4'd0; last = 4'd0; bus_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; req = 4'd0; last = 4'd0; data = 32'd0;
        bus_ready = 1'b0; prev_gnt = 4'd0; held_byte = 8'h00;
        clr_tally();
        @(posedge clk);
        #1;

        // Reset, including with ena low.
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_oe", 32'(uio_oe), 32'd0);
        do_reset();

        // Single requester, three-byte burst ended by last.
        clr_tally();
        req = 4'b0001; data = 32'h000000A5; bus_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            last = (ack_cnt == 2) ? 4'b0001 : 4'b0000;
            step();
            if (s == 0) chk("lat_gnt", 32'(gnt), 32'h1);
        end
        req = 4'd0; last = 4'd0;
        step();
        step();
        chk("s1_acks", 32'(ack_cnt), 32'd3);
        chk("s1_oe_cycles", 32'(oe_cnt), 32'd3);
        chk("s1_idle_busy", 32'(busy), 32'd0);

        // All four requesting with single-byte bursts: round-robin order.
        do_reset();
        clr_tally();
        req = 4'b1111; last = 4'b1111; bus_ready = 1'b1; data = $urandom;
        for (int s = 0; s < 14; s++) step();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        check_grants("rr");
        chk("rr_acks", 32'(ack_cnt), 32'd5);

        // No last: forced release at the burst limit, then regrant.
        do_reset();
        clr_tally();
        req = 4'b0100; last = 4'd0; bus_ready = 1'b1; data = $urandom;
        for (int s = 0; s < 11; s++) step();
        chk("max_acks", 32'(ack_cnt), 32'(MAXB));
        exp_q = '{2'd2};
        check_grants("max_g1");
        step();
        exp_q.push_back(2'd2);
        check_grants("max_g2");

        // Sink stall: no ack, data held, one ack once ready returns.
        do_reset();
        clr_tally();
        req = 4'b0010; last = 4'd0; bus_ready = 1'b1; data = $urandom;
        held_byte = data[15:8];
        step();
        bus_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("stall_out", 32'(uio_out), 32'(held_byte));
        end
        chk("stall_acks", 32'(ack_cnt), 32'd0);
        bus_ready = 1'b1;
        step();
        chk("stall_resume_acks", 32'(ack_cnt), 32'd1);
        req = 4'd0;
        step();
        step();

        // Abort by dropping the request mid-burst.
        do_reset();
        clr_tally();
        req = 4'b1000; last = 4'd0; bus_ready = 1'b1; data = $urandom;
        step(); step(); step();
        req = 4'd0;
        step();
        chk("abort_acks", 32'(ack_cnt), 32'd2);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        step();

        // Reset during a burst, then ena low while granted.
        do_reset();
        req = 4'b0001; bus_ready = 1'b1; data = $urandom;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_oe", 32'(uio_oe), 32'd0);
        chk("midrst_out", 32'(uio_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        clr_tally();
        step();
        ena = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("frozen_gnt", 32'(gnt), 32'h1);
        end
        chk("frozen_acks", 32'(ack_cnt), 32'd0);
        ena = 1'b1;
        step();
        chk("thaw_acks", 32'(ack_cnt), 32'd1);

        // Random traffic against the model.
        do_reset();
        for (int s = 0; s < 800; s++) begin
            rst       = ($urandom_range(0, 63) == 0);
            ena       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            last      = 4'($urandom) & 4'($urandom);
            bus_ready = ($urandom_range(0, 3) != 0);
            data      = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
